// File: rtl/cpu_pkg.sv
// Shared CPU definitions: M-extension funct3 encodings and the multiply/divide FSM states.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle on magnitudes,
// with the result sign applied once after the last iteration.
module muldiv_unit
   import cpu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   CNT_LAST   = CW'(XLEN - 1);
   localparam logic [CW-1:0]   CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ALL_ZEROS  = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t   state_r;
   muldiv_op_t      op_r;
   logic [XLEN-1:0] hi_r, lo_r, mcand_r, specRes_r, result_r;
   logic [CW-1:0]   cnt_r;
   logic            negRes_r, special_r, busy_r, done_r;

   muldiv_op_t      opIn_s;
   logic            aSigned_s, bSigned_s, aNeg_s, bNeg_s, isDiv_s, isRem_s;
   logic            divZero_s, sOvf_s, special_s, negRes_s;
   logic [XLEN-1:0] magA_s, magB_s, specRes_s, quo_s, rem_s, finalRes_s;
   logic [XLEN:0]   mulSum_s, remShift_s, divDiff_s;
   logic [2*XLEN-1:0] prod_s;

   // Operand decode at start: signedness, magnitudes, and the divide corner cases.
   always_comb begin
      opIn_s    = muldiv_op_t'(op);
      aSigned_s = 1'b0;
      bSigned_s = 1'b0;
      case (opIn_s)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            aSigned_s = 1'b1;
            bSigned_s = 1'b1;
         end
         OP_MULHSU: aSigned_s = 1'b1;
         default: begin
            aSigned_s = 1'b0;
            bSigned_s = 1'b0;
         end
      endcase
      aNeg_s    = aSigned_s & srcA[XLEN-1];
      bNeg_s    = bSigned_s & srcB[XLEN-1];
      magA_s    = aNeg_s ? -srcA : srcA;
      magB_s    = bNeg_s ? -srcB : srcB;
      isDiv_s   = op[2];
      isRem_s   = op[1];
      divZero_s = isDiv_s && (srcB == ALL_ZEROS);
      sOvf_s    = isDiv_s && aSigned_s && (srcA == SIGNED_MIN) && (srcB == ALL_ONES);
      special_s = divZero_s | sOvf_s;
      // A remainder follows the dividend's sign; everything else follows the operand sign product.
      if (isDiv_s && isRem_s) begin
         negRes_s = aNeg_s;
      end else begin
         negRes_s = aNeg_s ^ bNeg_s;
      end
      if (divZero_s) begin
         specRes_s = isRem_s ? srcA : ALL_ONES;
      end else begin
         specRes_s = isRem_s ? ALL_ZEROS : srcA;
      end
   end

   // Per-cycle datapath plus the final sign fix-up and result select.
   always_comb begin
      mulSum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
      remShift_s = {hi_r, lo_r[XLEN-1]};
      divDiff_s  = remShift_s - {1'b0, mcand_r};
      prod_s     = negRes_r ? -{hi_r, lo_r} : {hi_r, lo_r};
      quo_s      = negRes_r ? -lo_r : lo_r;
      rem_s      = negRes_r ? -hi_r : hi_r;
      if (special_r) begin
         finalRes_s = specRes_r;
      end else begin
         case (op_r)
            OP_MUL:                       finalRes_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: finalRes_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              finalRes_s = quo_s;
            OP_REM, OP_REMU:              finalRes_s = rem_s;
            default:                      finalRes_s = prod_s[XLEN-1:0];
         endcase
      end
   end

   // Control FSM and operand/accumulator registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         op_r      <= OP_MUL;
         hi_r      <= ALL_ZEROS;
         lo_r      <= ALL_ZEROS;
         mcand_r   <= ALL_ZEROS;
         specRes_r <= ALL_ZEROS;
         result_r  <= ALL_ZEROS;
         cnt_r     <= {CW{1'b0}};
         negRes_r  <= 1'b0;
         special_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else if (flush) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  op_r      <= opIn_s;
                  cnt_r     <= {CW{1'b0}};
                  hi_r      <= ALL_ZEROS;
                  lo_r      <= isDiv_s ? magA_s : magB_s;
                  mcand_r   <= isDiv_s ? magB_s : magA_s;
                  negRes_r  <= negRes_s;
                  special_r <= special_s;
                  specRes_r <= specRes_s;
                  busy_r    <= 1'b1;
                  state_r   <= (EARLY_OUT && special_s) ? ST_DONE : ST_CALC;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_CALC: begin
               cnt_r <= cnt_r + CNT_ONE;
               if (op_r[2]) begin
                  // Restoring step: keep the trial difference only when it did not go negative.
                  if (!divDiff_s[XLEN]) begin
                     hi_r <= divDiff_s[XLEN-1:0];
                     lo_r <= {lo_r[XLEN-2:0], 1'b1};
                  end else begin
                     hi_r <= remShift_s[XLEN-1:0];
                     lo_r <= {lo_r[XLEN-2:0], 1'b0};
                  end
               end else begin
                  hi_r <= mulSum_s[XLEN:1];
                  lo_r <= {mulSum_s[0], lo_r[XLEN-1:1]};
               end
               if (cnt_r == CNT_LAST) begin
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_CALC;
               end
            end
            ST_DONE: begin
               result_r <= finalRes_s;
               done_r   <= 1'b1;
               busy_r   <= 1'b0;
               state_r  <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter EARLY_OUT, default 1; when 1, divide-by-zero and signed-overflow divides complete without iterating.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 3 bits: M-extension funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The block SHALL have port srcA, input, XLEN bits: rs1 operand (multiplicand or dividend).
REQ-008 The block SHALL have port srcB, input, XLEN bits: rs2 operand (multiplier or divisor).
REQ-009 The block SHALL have port flush, input, 1 bit: abandon the current operation (branch flush of Execute).
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress; drives the pipeline stall.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-012 The block SHALL have port result, output, XLEN bits: last completed result, held until the next completion.

Function
REQ-013 The block SHALL implement states IDLE, CALC and DONE.
REQ-014 The block SHALL, in IDLE with start=1 and flush=0, latch op and the operands, clear the iteration counter, and enter CALC.
REQ-015 The block SHALL, in CALC, process one operand bit per cycle (shift-add multiply, restoring divide on magnitudes) for exactly XLEN cycles, then enter DONE.
REQ-016 The block SHALL, in DONE, assert done for exactly one cycle, update result, and return to IDLE.
REQ-017 The block SHALL give a latency of XLEN+1 cycles from the start-sampling edge to the done-high cycle (33 for XLEN=32).
REQ-018 The block SHALL drive busy = (state != IDLE).
REQ-019 The block SHALL ignore start when not in IDLE.
REQ-020 The block SHALL compute MUL as the low XLEN bits of the product, and MULH/MULHSU/MULHU as the high XLEN bits of the 2*XLEN product, with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-021 The block SHALL compute DIV/DIVU with the quotient rounded toward zero, and REM/REMU with the remainder taking the sign of the dividend.
REQ-022 The block SHALL apply signs by negating the magnitude result after the final iteration, never during iteration.
REQ-023 The block SHALL, for divisor zero, return quotient all-ones and remainder equal to the dividend.
REQ-024 The block SHALL, for signed overflow (dividend -2^(XLEN-1), divisor -1), return quotient equal to the dividend and remainder 0.
REQ-025 The block SHALL, with EARLY_OUT=1, go directly IDLE->DONE on the REQ-023/REQ-024 cases (done one cycle after start); with EARLY_OUT=0, iterate normally while still producing the REQ-023/REQ-024 results.
REQ-026 The block SHALL give flush=1 priority over everything but reset: any state goes to IDLE next cycle, done is not asserted, result is unchanged, and a simultaneous start is dropped.
REQ-027 The block SHALL keep the counter at clog2(XLEN)+1 bits, so that it never wraps inside an operation.

Reset
REQ-028 The block SHALL, on a clock edge with rst=0, enter IDLE and set busy=0, done=0, result=0 and the counter to 0, overriding start and flush, including mid-operation.

Structure
REQ-029 The block SHALL take the op encodings (enum muldiv_op_t) and the state enum (muldiv_state_t) from the shared package cpu_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the sign fix-up is inline logic.

Verification
REQ-031 The bench SHALL cover MUL 7 x 0xFFFFFFFD: result 0xFFFFFFEB, with done exactly 33 cycles after start.
REQ-032 The bench SHALL cover MULH 0x80000000 x 0x80000000 giving 0x40000000, and MULHU 0xFFFFFFFF x 0xFFFFFFFF giving 0xFFFFFFFE.
REQ-033 The bench SHALL cover DIV 0xFFFFFFF9 / 2 giving 0xFFFFFFFD, and REM of the same operands giving 0xFFFFFFFF.
REQ-034 The bench SHALL cover DIVU 5 / 0 giving 0xFFFFFFFF and REMU 5 / 0 giving 5, each with done one cycle after start (EARLY_OUT=1).
REQ-035 The bench SHALL cover DIV 0x80000000 / 0xFFFFFFFF giving 0x80000000, and REM of the same operands giving 0.
REQ-036 The bench SHALL cover flush and reset during CALC: flush on CALC cycle 10 gives busy=0 next cycle with no done; rst=0 mid-CALC gives all outputs 0; a following DIVU 100/7 returns 14 correctly.
